uart_tx_scheduler: RTL

Shares the single `uart_tx` byte transmitter among `NUM_REQ` byte-stream requesters, such as telemetry or debug sources. Requesters are served round-robin, one whole frame at a time. Each frame is sent as: sync byte, source-ID byte, 1..`MAX_LEN` payload bytes, XOR checksum byte. The block sits between the requesters and `uart_tx` and is the only driver of `uart_tx`'s `i_Tx_DV` and `i_Tx_Byte` inputs.

---
 rtl/uart_tx_sched_pkg.sv | 6 +
 rtl/uart_rr_arbiter.sv | 25 ++
 rtl/uart_tx_scheduler.sv | 131 +++++++++++++
 3 files changed

// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: state/phase encodings and defaults shared by the uart_tx scheduler
package uart_tx_sched_pkg;
   typedef enum logic [2:0] {IDLE, GRANT, ISSUE, WAIT, FETCH} state_t;
   typedef enum logic [1:0] {SYNC, ID, DATA, CSUM} phase_t;
   localparam logic [7:0] DEF_SYNC_BYTE = 8'hA5;
endpackage

// File: rtl/uart_rr_arbiter.sv
// uart_rr_arbiter: combinational cyclic priority pick starting just after the pointer
module uart_rr_arbiter #(
   parameter int N = 4,
   parameter int IW = $clog2(N)
) (
   input  logic [N-1:0]  req,
   input  logic [IW-1:0] ptr,
   output logic          found,
   output logic [IW-1:0] idx
);
   logic [IW-1:0] c;
   always_comb begin
      found = 1'b0;
      idx = '0;
      c = '0;
      // walk offsets from farthest to nearest so the nearest valid one wins
      for (int i = N; i >= 1; i--) begin
         c = IW'((int'(ptr) + i) % N);
         if (req[c]) begin
            found = 1'b1;
            idx = c;
         end
      end
   end
endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin framing of NUM_REQ byte streams onto one uart_tx
module uart_tx_scheduler
   import uart_tx_sched_pkg::*;
#(
   parameter int NUM_REQ = 4,
   parameter int MAX_LEN = 16,
   parameter logic [7:0] SYNC_BYTE = DEF_SYNC_BYTE,
   parameter int STALL_LIMIT = 4096,
   localparam int IW = $clog2(NUM_REQ),
   localparam int CW = $clog2(MAX_LEN + 1),
   localparam int SW = $clog2(STALL_LIMIT + 1)
) (
   input  logic                 i_Clock,
   input  logic                 i_Reset,
   input  logic [NUM_REQ-1:0]   i_Req_Valid,
   input  logic [8*NUM_REQ-1:0] i_Req_Data,
   input  logic [NUM_REQ-1:0]   i_Req_Last,
   output logic [NUM_REQ-1:0]   o_Req_Ready,
   output logic                 o_Tx_DV,
   output logic [7:0]           o_Tx_Byte,
   input  logic                 i_Tx_Active,
   input  logic                 i_Tx_Done,
   output logic                 o_Busy,
   output logic [IW-1:0]        o_Grant_Id,
   output logic                 o_Abort
);
   state_t state;
   phase_t phase;
   logic [IW-1:0] ptr, pick;
   logic found, done_q, done_rise, last_cap;
   logic [7:0] csum, req_byte;
   logic [CW-1:0] cnt;
   logic [SW-1:0] stall;

   uart_rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
      .req(i_Req_Valid),
      .ptr(ptr),
      .found(found),
      .idx(pick)
   );

   // uart_tx holds Done for two clocks; only its rising edge counts a byte
   assign done_rise = i_Tx_Done & ~done_q;
   assign req_byte = i_Req_Data[{o_Grant_Id, 3'b000} +: 8];

   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         state <= IDLE;
         phase <= SYNC;
         ptr <= IW'(NUM_REQ - 1);
         done_q <= 1'b0;
         last_cap <= 1'b0;
         csum <= '0;
         cnt <= '0;
         stall <= '0;
         o_Req_Ready <= '0;
         o_Tx_DV <= 1'b0;
         o_Tx_Byte <= '0;
         o_Busy <= 1'b0;
         o_Grant_Id <= '0;
         o_Abort <= 1'b0;
      end else begin
         done_q <= i_Tx_Done;
         o_Req_Ready <= '0;
         o_Abort <= 1'b0;
         case (state)
            IDLE: if (found && !i_Tx_Active) begin
               ptr <= pick;
               o_Grant_Id <= pick;
               o_Busy <= 1'b1;
               csum <= '0;
               cnt <= '0;
               stall <= '0;
               state <= GRANT;
            end
            GRANT: begin
               o_Tx_Byte <= SYNC_BYTE;
               phase <= SYNC;
               o_Tx_DV <= 1'b1;
               state <= ISSUE;
            end
            ISSUE: if (i_Tx_Active) begin
               o_Tx_DV <= 1'b0;
               state <= WAIT;
            end
            WAIT: if (done_rise) begin
               case (phase)
                  SYNC: begin
                     o_Tx_Byte <= 8'(o_Grant_Id);
                     csum <= 8'(o_Grant_Id);
                     phase <= ID;
                     o_Tx_DV <= 1'b1;
                     state <= ISSUE;
                  end
                  ID: state <= FETCH;
                  DATA: if (last_cap || cnt == CW'(MAX_LEN)) begin
                     o_Tx_Byte <= csum;
                     phase <= CSUM;
                     o_Tx_DV <= 1'b1;
                     state <= ISSUE;
                  end else state <= FETCH;
                  CSUM: begin
                     o_Busy <= 1'b0;
                     state <= IDLE;
                  end
               endcase
            end
            FETCH: if (i_Req_Valid[o_Grant_Id]) begin
               o_Req_Ready[o_Grant_Id] <= 1'b1;
               o_Tx_Byte <= req_byte;
               last_cap <= i_Req_Last[o_Grant_Id];
               csum <= csum ^ req_byte;
               cnt <= cnt + 1'b1;
               stall <= '0;
               phase <= DATA;
               o_Tx_DV <= 1'b1;
               state <= ISSUE;
            end else if (stall == SW'(STALL_LIMIT)) begin
               // starved requester: close the frame with what was sent so far
               o_Abort <= 1'b1;
               o_Tx_Byte <= csum;
               stall <= '0;
               phase <= CSUM;
               o_Tx_DV <= 1'b1;
               state <= ISSUE;
            end else stall <= stall + 1'b1;
            default: state <= IDLE;
         endcase
      end
   end
endmodule
